// File: rtl/store_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_queue_pkg
// Brief    : Shared entry type and default sizing for the store queue.
// Revision : 1.0 - initial release
// ============================================================================
package store_queue_pkg;

  localparam int SQ_DEPTH_DEFAULT = 8;
  localparam int SQ_ADDR_W        = 16;
  localparam int SQ_DATA_W        = 16;
  localparam int SQ_BE_W          = SQ_DATA_W / 8;

  typedef struct packed {
    logic                 wb;
    logic [SQ_ADDR_W-1:0] addr;
    logic [SQ_DATA_W-1:0] data;
    logic [SQ_BE_W-1:0]   be;
  } sq_entry_t;

endpackage
`default_nettype wire

// File: rtl/store_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : store_queue_if
// Brief    : Issue / writeback / commit / load-bypass / memory-drain bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface store_queue_if
  import store_queue_pkg::*;
#(
  parameter int SQ_DEPTH = SQ_DEPTH_DEFAULT,
  parameter int ADDR_W   = SQ_ADDR_W,
  parameter int DATA_W   = SQ_DATA_W
);
  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int BE_W  = DATA_W / 8;

  logic              issue_v_i;
  logic              issue_ready_o;
  logic [IDX_W-1:0]  issue_idx_o;

  logic              wb_v_i;
  logic [IDX_W-1:0]  wb_idx_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [DATA_W-1:0] wb_data_i;
  logic [BE_W-1:0]   wb_be_i;

  logic              commit_v_i;
  logic              commit_ready_o;
  logic              flush_i;

  logic [ADDR_W-1:0] ld_addr_i;
  logic [IDX_W-1:0]  ld_idx_i;
  logic [BE_W-1:0]   ld_be_i;
  logic              ld_hit_o;
  logic [DATA_W-1:0] ld_data_o;
  logic              ld_stall_o;

  logic              mem_v_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [BE_W-1:0]   mem_be_o;

  modport master (
    output issue_v_i, wb_v_i, wb_idx_i, wb_addr_i, wb_data_i, wb_be_i,
    output commit_v_i, flush_i, ld_addr_i, ld_idx_i, ld_be_i, mem_ready_i,
    input  issue_ready_o, issue_idx_o, commit_ready_o,
    input  ld_hit_o, ld_data_o, ld_stall_o,
    input  mem_v_o, mem_addr_o, mem_data_o, mem_be_o
  );

  modport slave (
    input  issue_v_i, wb_v_i, wb_idx_i, wb_addr_i, wb_data_i, wb_be_i,
    input  commit_v_i, flush_i, ld_addr_i, ld_idx_i, ld_be_i, mem_ready_i,
    output issue_ready_o, issue_idx_o, commit_ready_o,
    output ld_hit_o, ld_data_o, ld_stall_o,
    output mem_v_o, mem_addr_o, mem_data_o, mem_be_o
  );

endinterface
`default_nettype wire

// File: rtl/sq_youngest_match.sv
`default_nettype none
// ============================================================================
// Module   : sq_youngest_match
// Brief    : Picks the youngest set bit among the first LIMIT slots after BASE.
// Revision : 1.0 - initial release
// ============================================================================
module sq_youngest_match
  import store_queue_pkg::*;
#(
  parameter int DEPTH = SQ_DEPTH_DEFAULT
) (
  input  logic [DEPTH-1:0]         match,
  input  logic [$clog2(DEPTH)-1:0] base,
  input  logic [$clog2(DEPTH):0]   limit,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] sel
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DEPTH-1:0] w_rot;
  logic [IDX_W-1:0] w_off;

  // Slot k of the rotated vector is the k-th oldest entry counting from base.
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_rot
      logic [IDX_W-1:0] w_pos;
      assign w_pos    = base + IDX_W'(g);
      assign w_rot[g] = match[w_pos];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    w_off = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_rot[k] && (PTR_W'(k) < limit)) begin
        found = 1'b1;
        w_off = IDX_W'(k);
      end
    end
  end

  assign sel = base + w_off;

endmodule
`default_nettype wire

// File: rtl/store_queue.sv
`default_nettype none
// ============================================================================
// Module   : store_queue
// Brief    : Circular store queue with commit, flush, memory drain and load bypass.
// Revision : 1.0 - initial release
// ============================================================================
module store_queue
  import store_queue_pkg::*;
#(
  parameter int SQ_DEPTH = SQ_DEPTH_DEFAULT,
  parameter int ADDR_W   = SQ_ADDR_W,
  parameter int DATA_W   = SQ_DATA_W
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  store_queue_if.slave sq
);
  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = $clog2(SQ_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(SQ_DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_commit;
  logic [PTR_W-1:0] r_tail;
  sq_entry_t        r_ent [SQ_DEPTH];

  logic [IDX_W-1:0]    w_head_idx;
  logic [IDX_W-1:0]    w_commit_idx;
  logic [IDX_W-1:0]    w_tail_idx;
  logic [PTR_W-1:0]    w_live_cnt;
  logic [PTR_W-1:0]    w_spec_cnt;
  logic [PTR_W-1:0]    w_commit_off;
  logic [PTR_W-1:0]    w_commit_nxt;
  logic [IDX_W-1:0]    w_wb_off;
  logic                w_full;
  logic                w_issue_fire;
  logic                w_wb_fire;
  logic                w_commit_ready;
  logic                w_commit_fire;
  logic                w_mem_v;
  logic                w_mem_fire;
  logic [SQ_DEPTH-1:0] w_discard;

  logic [ADDR_W-1:0]   w_ld_addr;
  logic [IDX_W-1:0]    w_ld_off;
  logic [PTR_W-1:0]    w_ld_lim;
  logic [PTR_W-1:0]    w_older_lim;
  logic [SQ_DEPTH-1:0] w_match;
  logic [SQ_DEPTH-1:0] w_unres;
  logic                w_found;
  logic [IDX_W-1:0]    w_sel;
  logic [BE_W-1:0]     w_sel_be;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_cover;
  logic                w_stall;
  logic                w_hit;

  assign w_head_idx   = r_head[IDX_W-1:0];
  assign w_commit_idx = r_commit[IDX_W-1:0];
  assign w_tail_idx   = r_tail[IDX_W-1:0];
  assign w_live_cnt   = r_tail - r_head;
  assign w_spec_cnt   = r_tail - r_commit;
  assign w_commit_off = r_commit - r_head;
  assign w_full       = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);

  // Issue.
  assign sq.issue_ready_o = !w_full && !sq.flush_i;
  assign sq.issue_idx_o   = w_tail_idx;
  assign w_issue_fire     = sq.issue_v_i && sq.issue_ready_o;

  // Writeback only lands on allocated, not-yet-committed entries.
  assign w_wb_off  = sq.wb_idx_i - w_commit_idx;
  assign w_wb_fire = sq.wb_v_i && !sq.flush_i && ({1'b0, w_wb_off} < w_spec_cnt);

  // Commit.
  assign w_commit_ready    = (r_commit != r_tail) && r_ent[w_commit_idx].wb;
  assign sq.commit_ready_o = w_commit_ready;
  assign w_commit_fire     = sq.commit_v_i && w_commit_ready;
  assign w_commit_nxt      = w_commit_fire ? (r_commit + PTR_ONE) : r_commit;

  // Memory drain from head.
  assign w_mem_v       = (r_head != r_commit);
  assign w_mem_fire    = w_mem_v && sq.mem_ready_i;
  assign sq.mem_v_o    = w_mem_v;
  assign sq.mem_addr_o = r_ent[w_head_idx].addr;
  assign sq.mem_data_o = r_ent[w_head_idx].data;
  assign sq.mem_be_o   = r_ent[w_head_idx].be;

  // Entries between the post-commit pointer and tail are dropped on flush.
  generate
    for (genvar g = 0; g < SQ_DEPTH; g++) begin : g_discard
      logic [IDX_W-1:0] w_off;
      assign w_off        = IDX_W'(g) - w_commit_nxt[IDX_W-1:0];
      assign w_discard[g] = sq.flush_i && ({1'b0, w_off} < (r_tail - w_commit_nxt));
    end
  endgenerate

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_head   <= '0;
      r_commit <= '0;
      r_tail   <= '0;
      for (int i = 0; i < SQ_DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      if (w_mem_fire) begin
        r_head <= r_head + PTR_ONE;
      end
      r_commit <= w_commit_nxt;
      if (sq.flush_i) begin
        r_tail <= w_commit_nxt;
      end else if (w_issue_fire) begin
        r_tail <= r_tail + PTR_ONE;
      end
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (w_discard[i]) begin
          r_ent[i].wb <= 1'b0;
        end else if (w_issue_fire && (w_tail_idx == IDX_W'(i))) begin
          r_ent[i].wb <= 1'b0;
        end else if (w_wb_fire && (sq.wb_idx_i == IDX_W'(i))) begin
          r_ent[i].wb   <= 1'b1;
          r_ent[i].addr <= sq.wb_addr_i;
          r_ent[i].data <= sq.wb_data_i;
          r_ent[i].be   <= sq.wb_be_i;
        end
      end
    end
  end

  // A load whose captured tail equals head on a full queue sees every entry as older.
  assign w_ld_addr   = sq.ld_addr_i;
  assign w_ld_off    = sq.ld_idx_i - w_head_idx;
  assign w_ld_lim    = ((w_ld_off == '0) && w_full) ? PTR_DEPTH : {1'b0, w_ld_off};
  assign w_older_lim = (w_ld_lim < w_live_cnt) ? w_ld_lim : w_live_cnt;

  generate
    for (genvar g = 0; g < SQ_DEPTH; g++) begin : g_bypass
      logic [IDX_W-1:0] w_off;
      logic             w_older;
      assign w_off      = IDX_W'(g) - w_head_idx;
      assign w_older    = ({1'b0, w_off} < w_older_lim);
      assign w_match[g] = r_ent[g].wb && (r_ent[g].addr == w_ld_addr)
                          && (|(r_ent[g].be & sq.ld_be_i));
      assign w_unres[g] = w_older && ({1'b0, w_off} >= w_commit_off) && !r_ent[g].wb;
    end
  endgenerate

  sq_youngest_match #(
    .DEPTH (SQ_DEPTH)
  ) u_youngest (
    .match (w_match),
    .base  (w_head_idx),
    .limit (w_older_lim),
    .found (w_found),
    .sel   (w_sel)
  );

  assign w_sel_be   = r_ent[w_sel].be;
  assign w_sel_data = r_ent[w_sel].data;
  assign w_cover    = ((w_sel_be & sq.ld_be_i) == sq.ld_be_i);
  assign w_stall    = !sq.flush_i && ((|w_unres) || (w_found && !w_cover));
  assign w_hit      = !sq.flush_i && w_found && w_cover && !w_stall;

  assign sq.ld_stall_o = w_stall;
  assign sq.ld_hit_o   = w_hit;
  assign sq.ld_data_o  = w_hit ? w_sel_data : '0;

  a_commit_needs_ready : assert property (
    @(posedge clk_i) disable iff (!reset_ni) sq.commit_v_i |-> w_commit_ready
  );

endmodule
`default_nettype wire

// File: tb/tb_store_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_queue
// Brief    : Directed self-checking bench for store_queue (depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_queue;
  import store_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  store_queue_if #(.SQ_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) sq_if ();

  store_queue #(
    .SQ_DEPTH (DEPTH),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .sq       (sq_if)
  );

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  idx;
    logic [1:0]  be;
    logic        flush;
    logic        hit;
    logic        stall;
    logic [15:0] data;
  } ld_vec_t;

  ld_vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sq_if.issue_v_i   = 1'b0;
    sq_if.wb_v_i      = 1'b0;
    sq_if.wb_idx_i    = '0;
    sq_if.wb_addr_i   = '0;
    sq_if.wb_data_i   = '0;
    sq_if.wb_be_i     = '0;
    sq_if.commit_v_i  = 1'b0;
    sq_if.flush_i     = 1'b0;
    sq_if.ld_addr_i   = '0;
    sq_if.ld_idx_i    = '0;
    sq_if.ld_be_i     = '0;
    sq_if.mem_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  task automatic issue_one();
    sq_if.issue_v_i = 1'b1;
    tick();
    sq_if.issue_v_i = 1'b0;
  endtask

  task automatic wb(input logic [1:0] idx, input logic [15:0] addr,
                    input logic [15:0] data, input logic [1:0] be);
    sq_if.wb_v_i    = 1'b1;
    sq_if.wb_idx_i  = idx;
    sq_if.wb_addr_i = addr;
    sq_if.wb_data_i = data;
    sq_if.wb_be_i   = be;
    tick();
    sq_if.wb_v_i    = 1'b0;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    vecs[0] = '{16'h0040, 2'd2, 2'b11, 1'b0, 1'b1, 1'b0, 16'h2222};
    vecs[1] = '{16'h0040, 2'd1, 2'b11, 1'b0, 1'b1, 1'b0, 16'h1111};
    vecs[2] = '{16'h0040, 2'd3, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[3] = '{16'h0040, 2'd3, 2'b01, 1'b0, 1'b1, 1'b0, 16'h0033};
    vecs[4] = '{16'h0040, 2'd3, 2'b10, 1'b0, 1'b1, 1'b0, 16'h2222};
    vecs[5] = '{16'h0040, 2'd0, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000};
    vecs[6] = '{16'h0050, 2'd3, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000};
    vecs[7] = '{16'h0040, 2'd2, 2'b11, 1'b1, 1'b0, 1'b0, 16'h0000};
    vecs[8] = '{16'h0050, 2'd0, 2'b11, 1'b0, 1'b0, 1'b1, 16'h0000};

    // Reset state
    idle();
    reset_n = 1'b0;
    #3;
    do_reset();
    chk("rst_issue_ready", sq_if.issue_ready_o, 1);
    chk("rst_issue_idx", sq_if.issue_idx_o, 0);
    chk("rst_commit_ready", sq_if.commit_ready_o, 0);
    chk("rst_mem_v", sq_if.mem_v_o, 0);
    chk("rst_ld_hit", sq_if.ld_hit_o, 0);
    chk("rst_ld_stall", sq_if.ld_stall_o, 0);
    chk("rst_ld_data", sq_if.ld_data_o, 0);
    chk("rst_mem_addr", sq_if.mem_addr_o, 0);

    // Single store through commit and a stalled memory port
    sq_if.issue_v_i = 1'b1;
    #1;
    chk("p2_issue_idx", sq_if.issue_idx_o, 0);
    tick();
    sq_if.issue_v_i = 1'b0;
    wb(2'd1, 16'h0077, 16'h7777, 2'b11);
    sq_if.wb_v_i    = 1'b1;
    sq_if.wb_idx_i  = 2'd0;
    sq_if.wb_addr_i = 16'h0040;
    sq_if.wb_data_i = 16'hBEEF;
    sq_if.wb_be_i   = 2'b11;
    #1;
    chk("p2_commit_ready_same_cycle", sq_if.commit_ready_o, 0);
    tick();
    sq_if.wb_v_i = 1'b0;
    #1;
    chk("p2_commit_ready_next", sq_if.commit_ready_o, 1);
    sq_if.commit_v_i = 1'b1;
    #1;
    chk("p2_mem_v_before_commit", sq_if.mem_v_o, 0);
    tick();
    sq_if.commit_v_i = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("p2_hold_mem_v", sq_if.mem_v_o, 1);
      chk("p2_hold_mem_addr", sq_if.mem_addr_o, 32'h0040);
      chk("p2_hold_mem_data", sq_if.mem_data_o, 32'hBEEF);
      chk("p2_hold_mem_be", sq_if.mem_be_o, 2'b11);
      tick();
      #1;
    end
    sq_if.mem_ready_i = 1'b1;
    tick();
    sq_if.mem_ready_i = 1'b0;
    #1;
    chk("p2_mem_v_drained", sq_if.mem_v_o, 0);
    chk("p2_commit_ready_empty", sq_if.commit_ready_o, 0);
    sq_if.issue_v_i = 1'b1;
    #1;
    chk("p2_issue_idx1", sq_if.issue_idx_o, 1);
    tick();
    sq_if.issue_v_i = 1'b0;
    #1;
    chk("p2_stale_wb_ignored", sq_if.commit_ready_o, 0);

    // Fill to full, then load-bypass table
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      sq_if.issue_v_i = 1'b1;
      #1;
      chk("p3_issue_idx", sq_if.issue_idx_o, i);
      chk("p3_issue_ready", sq_if.issue_ready_o, 1);
      tick();
      sq_if.issue_v_i = 1'b0;
    end
    #1;
    chk("p3_full_not_ready", sq_if.issue_ready_o, 0);
    wb(2'd0, 16'h0040, 16'h1111, 2'b11);
    wb(2'd1, 16'h0040, 16'h2222, 2'b11);
    wb(2'd2, 16'h0040, 16'h0033, 2'b01);
    for (int v = 0; v < 9; v++) begin
      tick();
      sq_if.ld_addr_i = vecs[v].addr;
      sq_if.ld_idx_i  = vecs[v].idx;
      sq_if.ld_be_i   = vecs[v].be;
      sq_if.flush_i   = vecs[v].flush;
      #1;
      chk($sformatf("ld_hit[%0d]", v), sq_if.ld_hit_o, vecs[v].hit);
      chk($sformatf("ld_stall[%0d]", v), sq_if.ld_stall_o, vecs[v].stall);
      chk($sformatf("ld_data[%0d]", v), sq_if.ld_data_o, vecs[v].data);
      sq_if.flush_i = 1'b0;
    end
    sq_if.ld_addr_i = '0;
    sq_if.ld_be_i   = '0;
    sq_if.issue_v_i = 1'b1;
    #1;
    chk("p3_issue_full_ready", sq_if.issue_ready_o, 0);
    tick();
    sq_if.issue_v_i = 1'b0;
    #1;
    chk("p3_issue_full_ignored", sq_if.issue_idx_o, 0);
    sq_if.commit_v_i = 1'b1;
    tick();
    sq_if.commit_v_i = 1'b0;
    #1;
    chk("p3_mem_v", sq_if.mem_v_o, 1);
    chk("p3_mem_data", sq_if.mem_data_o, 32'h1111);
    sq_if.mem_ready_i = 1'b1;
    sq_if.issue_v_i   = 1'b1;
    #1;
    chk("p3_drain_same_cycle_ready", sq_if.issue_ready_o, 0);
    tick();
    sq_if.mem_ready_i = 1'b0;
    sq_if.issue_v_i   = 1'b0;
    #1;
    chk("p3_drain_next_ready", sq_if.issue_ready_o, 1);
    chk("p3_drain_tail_kept", sq_if.issue_idx_o, 0);
    chk("p3_drain_mem_v", sq_if.mem_v_o, 0);

    // Two committed, two speculative, flush together with a commit
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue_one();
    for (int i = 0; i < DEPTH; i++) begin
      wb(2'(i), 16'((i + 1) * 16), 16'(16'hA001 + i), 2'b11);
    end
    sq_if.commit_v_i = 1'b1;
    #1;
    chk("p4_commit_ready0", sq_if.commit_ready_o, 1);
    tick();
    #1;
    chk("p4_commit_ready1", sq_if.commit_ready_o, 1);
    tick();
    sq_if.flush_i = 1'b1;
    #1;
    chk("p4_flush_issue_ready", sq_if.issue_ready_o, 0);
    chk("p4_flush_commit_ready", sq_if.commit_ready_o, 1);
    chk("p4_flush_mem_v", sq_if.mem_v_o, 1);
    tick();
    sq_if.flush_i    = 1'b0;
    sq_if.commit_v_i = 1'b0;
    #1;
    chk("p4_post_commit_ready", sq_if.commit_ready_o, 0);
    chk("p4_post_issue_idx", sq_if.issue_idx_o, 3);
    chk("p4_post_issue_ready", sq_if.issue_ready_o, 1);
    sq_if.mem_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("p4_drain_mem_v", sq_if.mem_v_o, 1);
      chk("p4_drain_addr", sq_if.mem_addr_o, 32'((k + 1) * 16));
      chk("p4_drain_data", sq_if.mem_data_o, 32'(32'hA001 + k));
      tick();
      #1;
    end
    sq_if.mem_ready_i = 1'b0;
    chk("p4_drained", sq_if.mem_v_o, 0);
    issue_one();
    #1;
    chk("p4_reissue_not_ready", sq_if.commit_ready_o, 0);

    // Reset in the middle of a drain
    do_reset();
    issue_one();
    issue_one();
    wb(2'd0, 16'h0100, 16'hC0DE, 2'b11);
    wb(2'd1, 16'h0102, 16'hC0DF, 2'b11);
    sq_if.commit_v_i = 1'b1;
    tick();
    tick();
    sq_if.commit_v_i = 1'b0;
    #1;
    chk("p5_mem_v_before_rst", sq_if.mem_v_o, 1);
    reset_n = 1'b0;
    #1;
    chk("p5_rst_mem_v", sq_if.mem_v_o, 0);
    chk("p5_rst_issue_ready", sq_if.issue_ready_o, 1);
    chk("p5_rst_issue_idx", sq_if.issue_idx_o, 0);
    chk("p5_rst_commit_ready", sq_if.commit_ready_o, 0);
    #1;
    reset_n = 1'b1;
    tick();
    chk("p5_after_mem_v", sq_if.mem_v_o, 0);
    chk("p5_after_issue_idx", sq_if.issue_idx_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
